// File: rtl/alu.sv
// alu: 32-bit ALU with a registered result and 1-cycle latency.
// Define ALU_SLTU_EN to enable unsigned set-less-than on opcode 1010.
module alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operand_0,
  input  logic [WIDTH-1:0] operand_1,
  output logic             out_valid,
  output logic [WIDTH-1:0] result
);
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
`ifdef ALU_SLTU_EN
  localparam logic [3:0] OP_SLTU = 4'b1010;
  logic sltu;
`endif
  logic [WIDTH-1:0]   alu_res, result_d, result_q;
  logic [SHAMT_W-1:0] shamt;
  logic               slt, out_valid_d, out_valid_q;
  always_comb begin
    shamt = operand_1[SHAMT_W-1:0];
    slt   = $signed(operand_0) < $signed(operand_1);
`ifdef ALU_SLTU_EN
    sltu  = operand_0 < operand_1;
`endif
    alu_res = '0;
    case (opcode)
      OP_ADD:  alu_res = operand_0 + operand_1;
      OP_SUB:  alu_res = operand_0 - operand_1;
      OP_AND:  alu_res = operand_0 & operand_1;
      OP_OR:   alu_res = operand_0 | operand_1;
      OP_XOR:  alu_res = operand_0 ^ operand_1;
      OP_SLL:  alu_res = operand_0 << shamt;
      OP_SRL:  alu_res = operand_0 >> shamt;
      OP_SRA:  alu_res = $signed(operand_0) >>> shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
`ifdef ALU_SLTU_EN
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, sltu};
`endif
      default: alu_res = '0;
    endcase
    result_d    = in_valid ? alu_res : result_q;
    out_valid_d = in_valid;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign result    = result_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed scoreboard bench for alu; expected results queue at issue, compare on output.
module tb_alu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  opcode;
  logic [31:0] operand_0, operand_1;
  logic        out_valid;
  logic [31:0] result;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] held = '0;

  alu #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opcode(opcode),
    .operand_0(operand_0), .operand_1(operand_1),
    .out_valid(out_valid), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic collect();
    string t;
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed=out_valid %b expected=pending entry", out_valid);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, "_valid"}, {31'd0, out_valid}, 32'd1);
      check(t, result, e);
      held = e;
    end
  endtask

  task automatic push(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    in_valid  = 1'b1;
    opcode    = op;
    operand_0 = a;
    operand_1 = b;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    push(tag, op, a, b, exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    collect();
  endtask

  task automatic idle(input string tag);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_held"}, result, held);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; opcode = '0; operand_0 = '0; operand_1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", result, 32'd0);
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    idle("post_reset_idle");

    issue("add_wrap",  4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000);
    issue("sub_wrap",  4'b0001, 32'h00000000, 32'h00000001, 32'hFFFFFFFF);
    issue("add_5_7",   4'b0000, 32'd5, 32'd7, 32'd12);
    issue("and",       4'b0010, 32'hF0F0A5A5, 32'h0FF05A5A, 32'h00F00000);
    issue("or",        4'b0011, 32'hF0F0A5A5, 32'h0FF05A5A, 32'hFFF0FFFF);
    issue("xor",       4'b0100, 32'hF0F0A5A5, 32'h0FF05A5A, 32'hFF00FFFF);
    issue("sll_1",     4'b0110, 32'h80000001, 32'd1, 32'h00000002);
    issue("srl_1",     4'b0111, 32'h80000000, 32'd1, 32'h40000000);
    issue("sra_1",     4'b1000, 32'h80000000, 32'd1, 32'hC0000000);
    issue("sra_31",    4'b1000, 32'h80000000, 32'd31, 32'hFFFFFFFF);
    issue("sll_b32",   4'b0110, 32'h00000001, 32'h00000020, 32'h00000001);
    issue("srl_hi_b",  4'b0111, 32'h0000F000, 32'hFFFFFFE4, 32'h00000F00);
    issue("slt_neg",   4'b1001, 32'hFFFFFFFF, 32'd1, 32'd1);
    issue("slt_pos",   4'b1001, 32'd1, 32'hFFFFFFFF, 32'd0);
    issue("sll_0",     4'b0110, 32'hDEADBEEF, 32'd0, 32'hDEADBEEF);
    issue("slt_eq",    4'b1001, 32'd5, 32'd5, 32'd0);
    issue("add_pre",   4'b0000, 32'd1, 32'd2, 32'd3);
`ifdef ALU_SLTU_EN
    issue("op1010",    4'b1010, 32'd1, 32'hFFFFFFFF, 32'd1);
`else
    issue("op1010",    4'b1010, 32'd1, 32'hFFFFFFFF, 32'd0);
`endif
    issue("add_pre2",  4'b0000, 32'd9, 32'd9, 32'd18);
    issue("op0101",    4'b0101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0);
    issue("op1111",    4'b1111, 32'h12345678, 32'h1, 32'd0);

    // Three ops on consecutive edges must emerge in order, one per cycle.
    push("b2b_add", 4'b0000, 32'h10, 32'h20, 32'h30);
    @(posedge clk); #1;
    collect();
    push("b2b_sub", 4'b0001, 32'h100, 32'h1, 32'hFF);
    @(posedge clk); #1;
    collect();
    push("b2b_xor", 4'b0100, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555);
    @(posedge clk); #1;
    in_valid = 1'b0;
    collect();
    idle("idle_hold1");
    idle("idle_hold2");

    issue("add_nz", 4'b0000, 32'd5, 32'd7, 32'd12);
    push("inflight", 4'b0000, 32'd100, 32'd200, 32'd300);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_result", result, 32'd0);
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    exp_q.delete();
    tag_q.delete();
    held = '0;
    @(posedge clk); #1;
    check("rst_hold_result", result, 32'd0);
    check("rst_hold_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    idle("rst_release_idle");
    issue("after_rst", 4'b0001, 32'd10, 32'd3, 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
